// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared opcode, funct, state, aluop and alucont encodings for
//               the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // Encoding 4'd15 is deliberately left unused and recovers to FETCH1.
    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mc_aludec.sv
// ============================================================================
// Module      : mc_aludec
// Description : Combinational ALU decoder, (aluop, funct) -> alucont.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_aludec
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [1:0]      aluop,
    input  logic [OP_W-1:0] funct,
    output logic [2:0]      alucont
);

    always_comb begin
        alucont = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucont = ALUC_ADD;
            ALUOP_SUB: alucont = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucont = ALUC_ADD;
                    FUNCT_SUB: alucont = ALUC_SUB;
                    FUNCT_AND: alucont = ALUC_AND;
                    FUNCT_OR:  alucont = ALUC_OR;
                    FUNCT_SLT: alucont = ALUC_SLT;
                    default:   alucont = ALUC_ADD;
                endcase
            end
            default: alucont = ALUC_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module      : mc_ctrl
// Description : Multicycle Moore control FSM: 4-byte fetch, decode, execute of
//               LB/SB/R-type/BEQ/J/ADDI. Define MC_MEM_WAIT_EN for mem_rdy waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int IRW_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic [OP_W-1:0]  funct,
    input  logic             zero,
`ifdef MC_MEM_WAIT_EN
    input  logic             mem_rdy,
`endif
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsource,
    output logic [IRW_N-1:0] irwrite,
    output logic             pcen,
    output logic [2:0]       alucont
);

    state_t      state_q;
    state_t      state_d;
    logic        mem_ok;
    logic        pcwrite;
    logic        pcwritecond;
    logic        state_valid;
    logic [1:0]  aluop;
    logic [2:0]  alucont_dec;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = mem_rdy;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH1;
        case (state_q)
            S_FETCH1: state_d = mem_ok ? S_FETCH2 : S_FETCH1;
            S_FETCH2: state_d = mem_ok ? S_FETCH3 : S_FETCH2;
            S_FETCH3: state_d = mem_ok ? S_FETCH4 : S_FETCH3;
            S_FETCH4: state_d = mem_ok ? S_DECODE : S_FETCH4;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH1;
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LB:   state_d = S_LBRD;
                    OP_SB:   state_d = S_SBWR;
                    default: state_d = S_FETCH1;
                endcase
            end
            S_LBRD:    state_d = mem_ok ? S_LBWR : S_LBRD;
            S_LBWR:    state_d = S_FETCH1;
            S_SBWR:    state_d = mem_ok ? S_FETCH1 : S_SBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
            S_RTYPEWR: state_d = S_FETCH1;
            S_BEQEX:   state_d = S_FETCH1;
            S_JEX:     state_d = S_FETCH1;
            S_ADDIEX:  state_d = S_ADDIWR;
            S_ADDIWR:  state_d = S_FETCH1;
            default:   state_d = S_FETCH1;
        endcase
    end

    // IR slice loads and PC increments are qualified by mem_ok so a stalled
    // fetch byte is captured exactly once.
    always_comb begin
        memread     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        irwrite     = '0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        aluop       = ALUOP_ADD;
        state_valid = 1'b1;
        case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = mem_ok;
                irwrite = IRW_N'(mem_ok) << state_q[1:0];
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWR: regwrite = 1'b1;
            default:  state_valid = 1'b0;
        endcase
    end

    mc_aludec #(
        .OP_W (OP_W)
    ) u_aludec (
        .aluop   (aluop),
        .funct   (funct),
        .alucont (alucont_dec)
    );

    assign pcen    = pcwrite | (pcwritecond & zero);
    assign alucont = state_valid ? alucont_dec : 3'b000;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed self-checking bench for mc_ctrl; the stall scenario
//               is included when MC_MEM_WAIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_rdy = 1'b1;
    logic       memread, memwrite, iord, memtoreg, regdst, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] irwrite;
    logic [2:0] alucont;

    int errors = 0;
    int checks = 0;

    wire [18:0] obs = {memread, memwrite, iord, memtoreg, regdst, regwrite, alusrca,
                       alusrcb, pcsource, irwrite, pcen, alucont};

    mc_ctrl #(.OP_W(6), .IRW_N(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
`ifdef MC_MEM_WAIT_EN
        .mem_rdy  (mem_rdy),
`endif
        .memread  (memread),
        .memwrite (memwrite),
        .iord     (iord),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsource (pcsource),
        .irwrite  (irwrite),
        .pcen     (pcen),
        .alucont  (alucont)
    );

    always #5 clk = ~clk;

    // Field order: memread memwrite iord memtoreg regdst regwrite alusrca
    //              alusrcb pcsource irwrite pcen alucont
    function automatic logic [18:0] ev(input logic mr, input logic mw, input logic io,
                                       input logic mtr, input logic rd, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] ps, input logic [3:0] irw,
                                       input logic pe, input logic [2:0] ac);
        return {mr, mw, io, mtr, rd, rw, asa, asb, ps, irw, pe, ac};
    endfunction

    function automatic logic [18:0] fetch_v(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ev(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, one << k, 1, 3'b010);
    endfunction

    function automatic logic [18:0] decode_v();
        return ev(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 4'b0000, 0, 3'b010);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== fetch_v(0)) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs, fetch_v(0));
        end
    endtask

    task automatic test_reset_mid_rtype();
        logic [18:0] e;
        op = 6'b000000;
        funct = 6'b100000;
        for (int i = 0; i < 5; i++) step();
        e = ev(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 0, 3'b010);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL mid_rtypeex got=%h exp=%h", obs, e);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== fetch_v(0)) begin
            errors++;
            $display("FAIL reset_mid_fetch1 got=%h exp=%h", obs, fetch_v(0));
        end
        step();
        checks++;
        if (obs !== fetch_v(1)) begin
            errors++;
            $display("FAIL reset_mid_fetch2 got=%h exp=%h", obs, fetch_v(1));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_rtype_sub();
        logic [18:0] e[8];
        op = 6'b000000;
        funct = 6'b100010;
        for (int k = 0; k < 4; k++) e[k] = fetch_v(k);
        e[4] = decode_v();
        e[5] = ev(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 0, 3'b110);
        e[6] = ev(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 4'b0000, 0, 3'b010);
        e[7] = fetch_v(0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL rtype_sub cyc=%0d got=%h exp=%h", i, obs, e[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_alucont();
        logic [5:0] fn[5];
        logic [2:0] ac[5];
        logic [18:0] e;
        fn[0] = 6'b100000; ac[0] = 3'b010;
        fn[1] = 6'b100100; ac[1] = 3'b000;
        fn[2] = 6'b100101; ac[2] = 3'b001;
        fn[3] = 6'b101010; ac[3] = 3'b111;
        fn[4] = 6'b000111; ac[4] = 3'b010;
        op = 6'b000000;
        for (int t = 0; t < 5; t++) begin
            funct = fn[t];
            for (int i = 0; i < 5; i++) step();
            e = ev(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 0, ac[t]);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL alucont funct=%b got=%h exp=%h", fn[t], obs, e);
            end
            step();
            step();
        end
    endtask

    task automatic test_beq();
        logic [18:0] e[7];
        op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            for (int k = 0; k < 4; k++) e[k] = fetch_v(k);
            e[4] = decode_v();
            e[5] = ev(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 4'b0000, z[0], 3'b110);
            e[6] = fetch_v(0);
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL beq zero=%0d cyc=%0d got=%h exp=%h", z, i, obs, e[i]);
                end
                if (i < 6) step();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_lb_sb();
        logic [18:0] e[10];
        op = 6'b100000;
        for (int k = 0; k < 4; k++) e[k] = fetch_v(k);
        e[4] = decode_v();
        e[5] = ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0000, 0, 3'b010);
        e[6] = ev(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 3'b010);
        e[7] = ev(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 0, 3'b010);
        e[8] = fetch_v(0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL lb cyc=%0d got=%h exp=%h", i, obs, e[i]);
            end
            if (i < 8) step();
        end
        op = 6'b101000;
        e[6] = ev(0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 3'b010);
        e[7] = fetch_v(0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sb cyc=%0d got=%h exp=%h", i, obs, e[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_j_addi();
        logic [18:0] e[8];
        op = 6'b000010;
        for (int k = 0; k < 4; k++) e[k] = fetch_v(k);
        e[4] = decode_v();
        e[5] = ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0000, 1, 3'b010);
        e[6] = fetch_v(0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL j cyc=%0d got=%h exp=%h", i, obs, e[i]);
            end
            if (i < 6) step();
        end
        op = 6'b001000;
        e[5] = ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0000, 0, 3'b010);
        e[6] = ev(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 0, 3'b010);
        e[7] = fetch_v(0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL addi cyc=%0d got=%h exp=%h", i, obs, e[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_illegal_op();
        logic [18:0] e[6];
        op = 6'b111111;
        for (int k = 0; k < 4; k++) e[k] = fetch_v(k);
        e[4] = decode_v();
        e[5] = fetch_v(0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL illegal_op cyc=%0d got=%h exp=%h", i, obs, e[i]);
            end
            if (i < 5) step();
        end
    endtask

`ifdef MC_MEM_WAIT_EN
    task automatic test_mem_wait();
        logic [18:0] e;
        op = 6'b000000;
        mem_rdy = 1'b1;
        step();
        mem_rdy = 1'b0;
        #1;
        e = ev(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wait_fetch2 cyc=%0d got=%h exp=%h", i, obs, e);
            end
            step();
        end
        mem_rdy = 1'b1;
        #1;
        checks++;
        if (obs !== fetch_v(1)) begin
            errors++;
            $display("FAIL wait_release got=%h exp=%h", obs, fetch_v(1));
        end
        step();
        checks++;
        if (obs !== fetch_v(2)) begin
            errors++;
            $display("FAIL wait_fetch3 got=%h exp=%h", obs, fetch_v(2));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_mid_rtype();
        test_rtype_sub();
        test_alucont();
        test_beq();
        test_lb_sb();
        test_j_addi();
        test_illegal_op();
`ifdef MC_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
